// File: rtl/r_mul_iter.sv
// ---------------------------------------------------------------------------
// r_mul_iter
// Multicycle iterative signed multiplier for the PE functional units. It is
// the companion to the multicycle divider and uses the same en_i/valid_o
// handshake. A shift-add core retires K = log2(N_RADIX) multiplier bits per
// EXEC cycle, using only an N_BITS x K partial-product term. The operation
// is done on operand magnitudes, and the sign is applied on the last step.
//
// Ports:
//   clk_i    in   1       clock, rising edge
//   rst_n_i  in   1       asynchronous, active-low reset
//   en_i     in   1       start / keep-alive; high in IDLE or FINISH launches
//   a_i      in   N_BITS  signed multiplicand, captured at launch
//   b_i      in   N_BITS  signed multiplier, captured at launch
//   p_o      out  N_BITS  low half of signed product, registered
//   p_hi_o   out  N_BITS  high half of signed product (R_MUL_HIGH_EN only)
//   valid_o  out  1       one-cycle pulse while p_o holds a fresh result
//
// Configuration macro: R_MUL_HIGH_EN
//   defined   -> 2*N_BITS accumulator, p_hi_o port present
//   undefined -> N_BITS accumulator (partial products truncated), no p_hi_o
// ---------------------------------------------------------------------------
module r_mul_iter #(
  parameter int N_BITS  = 32,
  parameter int N_RADIX = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic [N_BITS-1:0] a_i,
  input  logic [N_BITS-1:0] b_i,
  output logic [N_BITS-1:0] p_o,
`ifdef R_MUL_HIGH_EN
  output logic [N_BITS-1:0] p_hi_o,
`endif
  output logic              valid_o
);

  localparam int K           = $clog2(N_RADIX);
  localparam int N_MUL_STAGE = N_BITS / K;
  localparam int CNT_W       = (N_MUL_STAGE > 1) ? $clog2(N_MUL_STAGE) : 1;
`ifdef R_MUL_HIGH_EN
  localparam int ACC_W       = 2 * N_BITS;
`else
  localparam int ACC_W       = N_BITS;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_MUL_STAGE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_FINISH
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [N_BITS-1:0]   r_aMag;
  logic [N_BITS-1:0]   r_bMag;
  logic                r_neg;
  logic                r_zero;
  logic [CNT_W-1:0]    r_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic [N_BITS-1:0]   r_p;
`ifdef R_MUL_HIGH_EN
  logic [N_BITS-1:0]   r_pHi;
`endif

  logic                w_launch;
  logic                w_lastStep;
  logic [K-1:0]        w_digit;
  logic [N_BITS+K-1:0] w_pp;
  logic [ACC_W-1:0]    w_ppShift;
  logic [ACC_W-1:0]    w_accNext;
  logic [ACC_W-1:0]    w_result;

  // A new operation may start from IDLE or directly out of FINISH, which
  // gives back-to-back operation without an idle bubble.
  assign w_launch   = ((r_state == S_IDLE) || (r_state == S_FINISH)) && en_i;
  assign w_lastStep = (r_state == S_EXEC) && en_i && (r_cnt == CNT_LAST);

  // One radix digit of the multiplier magnitude is consumed per cycle. The
  // N_BITS x K product is aligned to the digit position and accumulated.
  // In the narrow build the cast truncates to N_BITS. The low half is still
  // exact because all arithmetic is modulo 2^N_BITS.
  assign w_digit   = r_bMag[K*r_cnt +: K];
  assign w_pp      = {{K{1'b0}}, r_aMag} * {{N_BITS{1'b0}}, w_digit};
  assign w_ppShift = ACC_W'(w_pp) << (K*r_cnt);
  assign w_accNext = r_acc + w_ppShift;

  // The sign is applied after the magnitude product is complete. A zero
  // operand forces a clean zero, whatever the sign bits are.
  assign w_result  = r_zero ? '0 : (r_neg ? -w_accNext : w_accNext);

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic. valid_o is decoded from FINISH only, so it is exactly
  // one cycle wide. Dropping en_i during EXEC aborts the operation.
  always_comb begin
    w_stateNext = r_state;
    valid_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en_i) w_stateNext = S_EXEC;
      end
      S_EXEC: begin
        if (!en_i)                  w_stateNext = S_IDLE;
        else if (r_cnt == CNT_LAST) w_stateNext = S_FINISH;
      end
      S_FINISH: begin
        valid_o     = 1'b1;
        w_stateNext = en_i ? S_EXEC : S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Datapath. Operands are captured only on the launch edge, and they are
  // ignored at all other times. The result registers change only on the
  // last EXEC edge, so an abort leaves the previous result visible.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_aMag <= '0;
      r_bMag <= '0;
      r_neg  <= 1'b0;
      r_zero <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_p    <= '0;
`ifdef R_MUL_HIGH_EN
      r_pHi  <= '0;
`endif
    end else if (w_launch) begin
      r_aMag <= a_i[N_BITS-1] ? -a_i : a_i;
      r_bMag <= b_i[N_BITS-1] ? -b_i : b_i;
      r_neg  <= a_i[N_BITS-1] ^ b_i[N_BITS-1];
      r_zero <= (a_i == '0) || (b_i == '0);
      r_cnt  <= '0;
      r_acc  <= '0;
    end else if (r_state == S_EXEC) begin
      if (!en_i) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_lastStep) begin
        r_acc <= w_accNext;
        r_cnt <= '0;
        r_p   <= w_result[N_BITS-1:0];
`ifdef R_MUL_HIGH_EN
        r_pHi <= w_result[ACC_W-1 -: N_BITS];
`endif
      end else begin
        r_acc <= w_accNext;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign p_o    = r_p;
`ifdef R_MUL_HIGH_EN
  assign p_hi_o = r_pHi;
`endif

endmodule

// File: tb/tb_r_mul_iter.sv
// ---------------------------------------------------------------------------
// tb_r_mul_iter
// Directed testbench for r_mul_iter with N_BITS=32 and N_RADIX=4. This gives
// 16 EXEC cycles, and valid_o is seen in the 17th cycle after the launch
// edge. Inputs are driven on the falling edge, and outputs are sampled
// there as well.
// ---------------------------------------------------------------------------
module tb_r_mul_iter;

  logic        clk_i;
  logic        rst_n_i;
  logic        en_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [31:0] p_o;
  logic [31:0] p_hi_o;
  logic        valid_o;

  int assertCount = 0;
  int failCount   = 0;

  r_mul_iter #(.N_BITS(32), .N_RADIX(4)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (en_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .p_o     (p_o),
`ifdef R_MUL_HIGH_EN
    .p_hi_o  (p_hi_o),
`endif
    .valid_o (valid_o)
  );

`ifndef R_MUL_HIGH_EN
  assign p_hi_o = 32'h0;
`endif

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive the inputs at the next falling edge.
  task automatic applyStimulus(input logic en, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    en_i = en;
    a_i  = a;
    b_i  = b;
  endtask

  // Count falling edges until valid_o rises, with a bound of 40. The operand
  // inputs are scrambled meanwhile, because they must be ignored in EXEC.
  task automatic waitValid(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk_i);
      lat++;
      if (valid_o) break;
      a_i = $urandom;
      b_i = $urandom;
    end
  endtask

  // One complete operation with en_i dropped in FINISH.
  task automatic doOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] expP, input logic [31:0] expHi);
    int lat;
    applyStimulus(1'b1, a, b);
    waitValid(lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'd17);
    checkOutput({tag, " p_o"}, p_o, expP);
`ifdef R_MUL_HIGH_EN
    checkOutput({tag, " p_hi_o"}, p_hi_o, expHi);
`endif
    en_i = 1'b0;
    @(negedge clk_i);
    checkOutput({tag, " valid single pulse"}, {31'b0, valid_o}, 32'd0);
  endtask

  initial begin
    int  lat;
    bit  sawValid;
    rst_n_i = 1'b0;
    en_i    = 1'b0;
    a_i     = 32'h0;
    b_i     = 32'h0;
    repeat (3) @(negedge clk_i);
    checkOutput("reset p_o", p_o, 32'h0);
    checkOutput("reset valid_o", {31'b0, valid_o}, 32'd0);
    checkOutput("reset p_hi_o", p_hi_o, 32'h0);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    checkOutput("idle valid_o", {31'b0, valid_o}, 32'd0);

    doOp("7*-3",       32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
    doOp("0*-9",       32'd0,        32'hFFFF_FFF7, 32'h0000_0000, 32'h0000_0000);
    doOp("min*-1",     32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
    doOp("2^16*2^16",  32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001);
    doOp("max*max",    32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 32'h3FFF_FFFF);
    doOp("12345*-6789", 32'd12345,   32'(-6789),    32'hFB01_2863, 32'hFFFF_FFFF);

    // Back-to-back: en_i stays high, and the second operands are loaded in FINISH.
    applyStimulus(1'b1, 32'd6, 32'd7);
    waitValid(lat);
    checkOutput("b2b first latency", 32'(lat), 32'd17);
    checkOutput("b2b first p_o", p_o, 32'd42);
    a_i = 32'hFFFF_FFFB;
    b_i = 32'd5;
    waitValid(lat);
    checkOutput("b2b second spacing", 32'(lat), 32'd17);
    checkOutput("b2b second p_o", p_o, 32'hFFFF_FFE7);
    en_i = 1'b0;
    @(negedge clk_i);
    checkOutput("b2b valid drops", {31'b0, valid_o}, 32'd0);

    // Abort: a prior result of 42, then en_i is dropped in the cycle where cnt=5.
    doOp("6*7 pre-abort", 32'd6, 32'd7, 32'd42, 32'd0);
    applyStimulus(1'b1, 32'd3, 32'd3);
    repeat (6) @(negedge clk_i);
    en_i = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      sawValid = sawValid | valid_o;
    end
    checkOutput("abort no valid", {31'b0, sawValid}, 32'd0);
    checkOutput("abort p_o held", p_o, 32'd42);

    // Asynchronous reset in the middle of EXEC.
    applyStimulus(1'b1, 32'd9, 32'd9);
    repeat (8) @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    checkOutput("mid reset p_o", p_o, 32'h0);
    checkOutput("mid reset valid_o", {31'b0, valid_o}, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    en_i    = 1'b0;
    repeat (20) @(negedge clk_i);
    checkOutput("post reset idle valid", {31'b0, valid_o}, 32'd0);
    doOp("post reset 7*-3", 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
